mem_bus_router: RTL and testbench
=================================

# mem_bus_router

Parametrised successor to the fixed four-bank memory bus. It decodes a CPU address against NUM_REGIONS programmable base/mask windows, launches a latched access to the selected region, and inserts per-region fixed wait states. It also honours a per-region variable-latency ready handshake and stalls the CPU through bus_halt until the access completes. Unmapped addresses, writes to read-only regions and ready timeouts terminate the access with a one-cycle bus_error.

## Interface
- NUM_REGIONS, 4: number of decoded regions (1..8).
- ADDR_WIDTH, 24: CPU address width.
- DATA_WIDTH, 8: data width.
- REGION_BASE, {24'h00_0000,24'h00_4000,24'h00_8000,24'h00_C000}: packed NUM_REGIONS×ADDR_WIDTH base addresses.
- REGION_MASK, {24'hFF_C000 ×3, 24'h00_0000}: packed compare masks; a region hits when (address & mask) == (base & mask).
- WAIT_STATES, all 0: packed NUM_REGIONS×4 fixed wait cycles.
- READ_ONLY, 4'b0010: per-region write-protect bit.
- TIMEOUT_CYCLES, 1023: maximum cycles waiting on region_ready.
- DEFAULT_DATA, 8'hFF: data_out value on error.
- Ports:
  - clk  in  1  system clock; all state on rising edge.
  - reset  in  1  asynchronous, active-low reset.
  - address  in  ADDR_WIDTH  CPU address.
  - data_in  in  DATA_WIDTH  CPU write data.
  - data_out  out  DATA_WIDTH  registered read data.
  - bus_enable  in  1  CPU access request.
  - write_enable  in  1  access is a write.
  - bus_halt  out  1  CPU stall.
  - bus_error  out  1  one-cycle error pulse.
  - region_select  out  NUM_REGIONS  one-hot region enable.
  - region_write_enable  out  NUM_REGIONS  one-hot write strobe.
  - region_address  out  ADDR_WIDTH  latched address.
  - region_wdata  out  DATA_WIDTH  latched write data.
  - region_rdata  in  NUM_REGIONS×DATA_WIDTH  packed region read data.
  - region_ready  in  NUM_REGIONS  region access complete.

## Operation
- **States:** IDLE, WAIT, ACCESS, DONE, ERROR.
- **IDLE:**
  - On bus_enable, latch address, data_in, write_enable and the decoded region index. Decode is priority-encoded; the lowest index wins on overlap.
  - No hit, or a write to a READ_ONLY region: go to ERROR. No region strobe is asserted.
  - Otherwise, load the wait counter with WAIT_STATES[idx]. Go to WAIT if it is nonzero, else ACCESS.
- **WAIT:** region_select[idx] high. Decrement the counter; go to ACCESS when it reaches 1.
- **ACCESS:**
  - region_select[idx] high, and region_write_enable[idx] high if the access is a write.
  - On region_ready[idx], capture region_rdata[idx] into data_out (reads only) and go to DONE.
  - The timeout counter increments every ACCESS cycle. If it reaches TIMEOUT_CYCLES without ready, go to ERROR.
- **DONE:** all strobes low. Go to IDLE unconditionally.
- **ERROR:** bus_error high, data_out = DEFAULT_DATA for reads, all strobes low. Go to IDLE.
- **bus_halt** = bus_enable && state ∉ {DONE, ERROR}.
  - This is combinational, so the stall is visible in the same cycle as the request.
- **Write data:** data_out holds its last value on writes.
- **Protocol:** the CPU shall hold bus_enable, address and write_enable stable until bus_halt falls.
  - If bus_enable drops mid-access, the router still completes the launched access. Region side effects are never aborted.
- **Reset (asserted low, any state):**
  - state = IDLE; all strobes, bus_error and counters = 0; data_out = 0; region_address = 0; region_wdata = 0.
  - Because it is asynchronous, region strobes drop immediately, even mid-access.

## Timing
- Minimum access (0 wait states, region_ready tied high): request seen in cycle 0 (IDLE), ACCESS in cycle 1, DONE in cycle 2.
  - bus_halt is high in cycles 0–1 and low in cycle 2.
  - data_out is valid from cycle 2.
- Latency = 2 + WAIT_STATES[idx] + (ready delay in ACCESS cycles).
- Error latency: decode error reaches ERROR in cycle 1. Timeout errors occur in cycle 1 + WAIT_STATES + TIMEOUT_CYCLES.
- Back-to-back requests: DONE→IDLE costs one cycle. Peak throughput is one access per 3 cycles.
- region_ready is sampled only in ACCESS and only for the selected index. Ready from other regions is ignored.
- Counter widths:
  - Wait counter: 4 bits.
  - Timeout counter: $clog2(TIMEOUT_CYCLES+1) bits, saturating compare, no wrap.

## Structure
- Shared package mem_bus_pkg holds:
  - the state encoding (3-bit localparams);
  - the maximum NUM_REGIONS (8);
  - the wait-counter width.
- Sub-module region_decoder: purely combinational.
  - Inputs: address, REGION_BASE, REGION_MASK, READ_ONLY.
  - Outputs: hit, index, read_only.
  - Instantiated once.
- All sequential logic (FSM, latches, counters) lives in mem_bus_router.

## Test plan
- Read at 0x000010 (region 0, 0 wait states, ready tied high, rdata 0x5A): bus_halt high 2 cycles, data_out = 0x5A in cycle 2, region_select = 4'b0001 for exactly 1 cycle.
- Write 0xA5 to 0x004000 (region 1, READ_ONLY): bus_error pulses in cycle 1, region_write_enable never asserts, bus_halt low in cycle 1.
- Region 3 with WAIT_STATES = 3 and ready delayed 2 cycles, read 0x123456: bus_halt high 7 cycles, data captured on the ready edge.
- Region 2 with ready held low and TIMEOUT_CYCLES = 15: bus_error after 16 cycles, data_out = 0xFF, FSM returns to IDLE.
- Overlapping windows (regions 0 and 2 both hit): region 0 selected. With REGION_MASK = all ones and no matching base: error, data_out = 0xFF.
- Reset asserted during region 3 ACCESS: region_select drops asynchronously. After release, the next read completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding and widths for the region-decoded memory bus router.
package mem_bus_pkg;
  localparam int MAX_REGIONS = 8;
  localparam int IDX_W = $clog2(MAX_REGIONS);
  localparam int WAIT_W = 4;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;
endpackage

// File: rtl/region_decoder.sv
// region_decoder: combinational base/mask window match; lowest matching index wins.
module region_decoder
  import mem_bus_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_WIDTH = 24,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = '0,
  parameter logic [NUM_REGIONS-1:0] READ_ONLY = '0
) (
  input  logic [ADDR_WIDTH-1:0] address,
  output logic                  hit,
  output logic [IDX_W-1:0]      index,
  output logic                  read_only
);
  always_comb begin
    hit = 1'b0;
    index = '0;
    read_only = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((address & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit = 1'b1;
        index = IDX_W'(i);
        read_only = READ_ONLY[i];
      end
    end
  end
endmodule

// File: rtl/mem_bus_router.sv
// mem_bus_router: decodes CPU accesses onto programmable regions with wait states,
// a ready handshake with timeout, and a one-cycle error pulse for failed accesses.
module mem_bus_router
  import mem_bus_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
    {24'h00_C000, 24'h00_8000, 24'h00_4000, 24'h00_0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
    {24'h00_0000, 24'hFF_C000, 24'hFF_C000, 24'hFF_C000},
  parameter logic [NUM_REGIONS*WAIT_W-1:0] WAIT_STATES = '0,
  parameter logic [NUM_REGIONS-1:0] READ_ONLY = 4'b0010,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = 8'hFF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic [DATA_WIDTH-1:0]             data_in,
  output logic [DATA_WIDTH-1:0]             data_out,
  input  logic                              bus_enable,
  input  logic                              write_enable,
  output logic                              bus_halt,
  output logic                              bus_error,
  output logic [NUM_REGIONS-1:0]            region_select,
  output logic [NUM_REGIONS-1:0]            region_write_enable,
  output logic [ADDR_WIDTH-1:0]             region_address,
  output logic [DATA_WIDTH-1:0]             region_wdata,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] region_rdata,
  input  logic [NUM_REGIONS-1:0]            region_ready
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d, dec_idx;
  logic                   we_q, we_d, dec_hit, dec_ro, rdy;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, dout_q, dout_d, rdata;
  logic [WAIT_W-1:0]      wait_q, wait_d, wait_ld;
  logic [TO_W-1:0]        to_q, to_d;
  logic [NUM_REGIONS-1:0] sel_oh;

  region_decoder #(
    .NUM_REGIONS(NUM_REGIONS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REGION_BASE(REGION_BASE),
    .REGION_MASK(REGION_MASK),
    .READ_ONLY  (READ_ONLY)
  ) u_dec (
    .address  (address),
    .hit      (dec_hit),
    .index    (dec_idx),
    .read_only(dec_ro)
  );

  // Index-driven selects written as loops so no index is wider than its vector.
  always_comb begin
    sel_oh = '0;
    rdata = '0;
    wait_ld = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      sel_oh[i] = idx_q == IDX_W'(i);
      rdata = (idx_q == IDX_W'(i)) ? region_rdata[i*DATA_WIDTH +: DATA_WIDTH] : rdata;
      wait_ld = (dec_idx == IDX_W'(i)) ? WAIT_STATES[i*WAIT_W +: WAIT_W] : wait_ld;
    end
  end

  assign rdy = |(region_ready & sel_oh);

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wait_d = wait_q;
    to_d = to_q;
    dout_d = dout_q;
    case (state_q)
      S_IDLE: if (bus_enable) begin
        idx_d = dec_idx;
        we_d = write_enable;
        addr_d = address;
        wdata_d = data_in;
        wait_d = wait_ld;
        to_d = '0;
        if (!dec_hit || (write_enable && dec_ro)) begin
          state_d = S_ERROR;
          dout_d = write_enable ? dout_q : DEFAULT_DATA;
        end else state_d = (|wait_ld) ? S_WAIT : S_ACCESS;
      end
      S_WAIT: begin
        wait_d = wait_q - 1'b1;
        state_d = (wait_q == WAIT_W'(1)) ? S_ACCESS : S_WAIT;
      end
      S_ACCESS: if (rdy) begin
        state_d = S_DONE;
        dout_d = we_q ? dout_q : rdata;
      end else if (to_q >= TO_LAST) begin
        state_d = S_ERROR;
        dout_d = we_q ? dout_q : DEFAULT_DATA;
      end else to_d = to_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wait_q <= '0;
      to_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wait_q <= wait_d;
      to_q <= to_d;
      dout_q <= dout_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign region_select = (state_q == S_WAIT || state_q == S_ACCESS) ? sel_oh : '0;
  assign region_write_enable = (state_q == S_ACCESS && we_q) ? sel_oh : '0;
  assign bus_error = state_q == S_ERROR;
  assign bus_halt = bus_enable && !(state_q == S_DONE || state_q == S_ERROR);
  assign data_out = dout_q;
  assign region_address = addr_q;
  assign region_wdata = wdata_q;
endmodule

// File: tb/tb_mem_bus_router.sv
// tb_mem_bus_router: randomized and directed accesses checked cycle by cycle
// against an address-range reference model of the router.
module tb_mem_bus_router;
  localparam int TMO = 15;
  localparam logic [23:0] LO_M [4] = '{24'h000000, 24'h004000, 24'h000000, 24'h120000};
  localparam logic [23:0] HI_M [4] = '{24'h003FFF, 24'h007FFF, 24'h00FFFF, 24'h12FFFF};
  localparam int WS_M [4] = '{0, 2, 0, 3};
  localparam bit RO_M [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic        clk = 1'b0, reset = 1'b1;
  logic [23:0] address = '0, region_address;
  logic [7:0]  data_in = '0, data_out, region_wdata;
  logic        bus_enable = 1'b0, write_enable = 1'b0, bus_halt, bus_error;
  logic [3:0]  region_select, region_write_enable, region_ready = '0;
  logic [31:0] region_rdata = '0;
  logic [7:0]  dout_m = '0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mem_bus_router #(
    .NUM_REGIONS(4), .ADDR_WIDTH(24), .DATA_WIDTH(8),
    .REGION_BASE({24'h120000, 24'h008000, 24'h004000, 24'h000000}),
    .REGION_MASK({24'hFF0000, 24'hFF0000, 24'hFFC000, 24'hFFC000}),
    .WAIT_STATES({4'd3, 4'd0, 4'd2, 4'd0}),
    .READ_ONLY(4'b0010), .TIMEOUT_CYCLES(TMO), .DEFAULT_DATA(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in), .data_out(data_out),
    .bus_enable(bus_enable), .write_enable(write_enable), .bus_halt(bus_halt),
    .bus_error(bus_error), .region_select(region_select),
    .region_write_enable(region_write_enable), .region_address(region_address),
    .region_wdata(region_wdata), .region_rdata(region_rdata), .region_ready(region_ready)
  );

  function automatic int model_region(input logic [23:0] a);
    for (int i = 0; i < 4; i++) if (a >= LO_M[i] && a <= HI_M[i]) return i;
    return -1;
  endfunction

  // d: ACCESS cycles before the selected region raises ready; drop: cycle bus_enable falls (0 = held).
  task automatic run_txn(input logic [23:0] a, input logic w, input logic [7:0] wd,
                         input logic [31:0] rd, input int d, input int drop);
    int r, ws, last;
    bit err, tmo;
    logic [3:0] oh, e_sel, e_wen;
    logic [7:0] e_dout;
    logic e_halt, e_err;
    r = model_region(a);
    err = (r < 0) ? 1'b1 : (w && RO_M[r]);
    ws = err ? 0 : WS_M[r];
    tmo = !err && d >= TMO;
    last = err ? 1 : tmo ? 1 + ws + TMO : 2 + ws + d;
    oh = err ? 4'b0 : 4'(1 << r);
    e_dout = w ? dout_m : (err || tmo) ? 8'hFF : 8'(rd >> (8 * r));
    @(negedge clk);
    address = a; write_enable = w; data_in = wd; region_rdata = rd;
    region_ready = 4'($urandom); bus_enable = 1'b1;
    #1;
    checks++;
    if (bus_halt !== 1'b1) begin errors++; $display("FAIL halt_c0 addr=%h got=%b exp=1", a, bus_halt); end
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (drop == c) bus_enable = 1'b0;
      region_ready = 4'($urandom);
      if (!err && c > ws) region_ready[r] = (c >= 1 + ws + d);
      #1;
      e_sel = (c < last) ? oh : 4'b0;
      e_wen = (w && c > ws && c < last) ? oh : 4'b0;
      e_halt = bus_enable && c < last;
      e_err = (err || tmo) && c == last;
      checks++;
      if (region_select !== e_sel) begin errors++; $display("FAIL select addr=%h c=%0d got=%b exp=%b", a, c, region_select, e_sel); end
      checks++;
      if (region_write_enable !== e_wen) begin errors++; $display("FAIL wstrobe addr=%h c=%0d got=%b exp=%b", a, c, region_write_enable, e_wen); end
      checks++;
      if (bus_halt !== e_halt) begin errors++; $display("FAIL halt addr=%h c=%0d got=%b exp=%b", a, c, bus_halt, e_halt); end
      checks++;
      if (bus_error !== e_err) begin errors++; $display("FAIL error addr=%h c=%0d got=%b exp=%b", a, c, bus_error, e_err); end
      if (c == last) begin
        checks++;
        if (data_out !== e_dout) begin errors++; $display("FAIL data_out addr=%h got=%h exp=%h", a, data_out, e_dout); end
      end
      if (c == 1 && !err) begin
        checks++;
        if (region_address !== a) begin errors++; $display("FAIL raddr got=%h exp=%h", region_address, a); end
        if (w) begin
          checks++;
          if (region_wdata !== wd) begin errors++; $display("FAIL wdata got=%h exp=%h", region_wdata, wd); end
        end
      end
    end
    bus_enable = 1'b0;
    dout_m = e_dout;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL rst_dout got=%h exp=00", data_out); end
    checks++;
    if (region_select !== 4'b0 || region_write_enable !== 4'b0) begin
      errors++; $display("FAIL rst_strobes got=%b/%b exp=0000/0000", region_select, region_write_enable);
    end
    checks++;
    if (bus_error !== 1'b0 || bus_halt !== 1'b0) begin
      errors++; $display("FAIL rst_err_halt got=%b/%b exp=0/0", bus_error, bus_halt);
    end
    checks++;
    if (region_address !== 24'h0 || region_wdata !== 8'h0) begin
      errors++; $display("FAIL rst_latches got=%h/%h exp=0/0", region_address, region_wdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dout_m = 8'h00;
  endtask

  task automatic test_basic();
    run_txn(24'h000010, 1'b0, 8'h00, 32'h0000005A, 0, 0);
    run_txn(24'h004000, 1'b1, 8'hA5, $urandom, 0, 0);
    run_txn(24'h000020, 1'b1, 8'h3C, $urandom, 0, 0);
  endtask

  task automatic test_wait_ready();
    run_txn(24'h123456, 1'b0, 8'h00, 32'h77000000, 2, 0);
    run_txn(24'h004010, 1'b0, 8'h00, 32'h00001200, 1, 0);
  endtask

  task automatic test_timeout();
    run_txn(24'h008000, 1'b0, 8'h00, 32'h00C30000, 1000, 0);
    run_txn(24'h008004, 1'b1, 8'h11, $urandom, 1000, 0);
    run_txn(24'h008008, 1'b0, 8'h00, 32'h00990000, 14, 0);
  endtask

  task automatic test_overlap_unmapped();
    run_txn(24'h000010, 1'b0, 8'h00, 32'h00EE0042, 0, 0);
    run_txn(24'h400000, 1'b0, 8'h00, $urandom, 0, 0);
    run_txn(24'h000030, 1'b0, 8'h00, 32'h0000001B, 0, 0);
    run_txn(24'hFFFFFF, 1'b1, 8'h55, $urandom, 0, 0);
  endtask

  task automatic test_enable_drop();
    run_txn(24'h120000, 1'b0, 8'h00, 32'h6D000000, 1, 2);
    run_txn(24'h12ABCD, 1'b1, 8'h9E, $urandom, 0, 1);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    address = 24'h123456; write_enable = 1'b0; region_rdata = $urandom;
    region_ready = 4'b0; bus_enable = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (region_select !== 4'b1000) begin errors++; $display("FAIL pre_rst_sel got=%b exp=1000", region_select); end
    reset = 1'b0;
    #1;
    checks++;
    if (region_select !== 4'b0000) begin errors++; $display("FAIL async_rst_sel got=%b exp=0000", region_select); end
    checks++;
    if (data_out !== 8'h00 || region_address !== 24'h0) begin
      errors++; $display("FAIL async_rst_regs got=%h/%h exp=00/000000", data_out, region_address);
    end
    bus_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    dout_m = 8'h00;
    run_txn(24'h123456, 1'b0, 8'h00, 32'hA1000000, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_txn(24'h000100 + 24'(i), 1'b0, 8'h00, $urandom, 0, 0);
  endtask

  task automatic test_random();
    logic [23:0] a;
    int cat, d, drop;
    for (int i = 0; i < 40; i++) begin
      cat = $urandom_range(0, 4);
      a = (cat == 0) ? 24'h000000 : (cat == 1) ? 24'h004000 : (cat == 2) ? 24'h008000 :
          (cat == 3) ? 24'h120000 : 24'h400000;
      a = a + 24'($urandom_range(0, 'h3FFF));
      d = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_txn(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom, d, drop);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_ready();
    test_timeout();
    test_overlap_unmapped();
    test_enable_drop();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
